// File: rtl/pb_irq_ctrl.sv
// pb_irq_ctrl: eight-source interrupt controller for the KCPSM6 interrupt/interrupt_ack pair.
// Collects event lines into PENDING, gates them with MASK, and runs an IDLE/REQ/SERVICE
// handshake. PENDING (+0, W1C), MASK (+1), CAUSE (+2) and EOI (+3) sit on the I/O port bus.
// Build option: define PB_IRQ_EDGE_EN for rising-edge capture of irq_src. With it undefined,
// each source is captured as a level.

module pb_irq_ctrl #(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [7:0]  BASE_PORT = 8'hF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               interrupt,
  input  logic               interrupt_ack,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         in_port
);

  localparam logic [7:0] AddrPend  = BASE_PORT;
  localparam logic [7:0] AddrMask  = BASE_PORT + 8'd1;
  localparam logic [7:0] AddrCause = BASE_PORT + 8'd2;
  localparam logic [7:0] AddrEoi   = BASE_PORT + 8'd3;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StService = 2'd2;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [7:0]         cause_q, cause_d;
  logic [1:0]         state_q, state_d;
  logic [7:0]         in_port_q, in_port_d;

  logic [NUM_SRC-1:0] events;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c_bits;
  logic               req;
  logic [2:0]         cause_idx;
  logic               wr_pend, wr_mask, wr_eoi;
  logic [7:0]         pend8, mask8;

  // Reads have no side effects, so the read qualifier is intentionally not consumed.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

`ifdef PB_IRQ_EDGE_EN
  logic [NUM_SRC-1:0] src_hist_q, src_hist_d;

  // Edge history: previous-cycle copy of irq_src; a 0->1 change is an event.
  always_comb begin
    src_hist_d = irq_src;
    events     = irq_src & ~src_hist_q;
  end

  // Edge-history register.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_hist_q <= '0;
    end else begin
      src_hist_q <= src_hist_d;
    end
  end
`else
  // Level capture: a high source re-sets its pending bit every cycle.
  always_comb begin
    events = irq_src;
  end
`endif

  // Full 8-bit write decode; unmapped addresses fall through untouched.
  always_comb begin
    wr_pend  = write_strobe && (port_id == AddrPend);
    wr_mask  = write_strobe && (port_id == AddrMask);
    wr_eoi   = write_strobe && (port_id == AddrEoi);
    w1c_bits = wr_pend ? out_port[NUM_SRC-1:0] : '0;
  end

  // Pending and mask next state; the OR of new events after the W1C makes set win over clear.
  always_comb begin
    pending_d = (pending_q & ~w1c_bits) | events;
    mask_d    = wr_mask ? out_port[NUM_SRC-1:0] : mask_q;
    active    = pending_q & mask_q;
    req       = |active;
  end

  // Lowest-index enabled pending source; scanning downwards lets the lowest index win.
  always_comb begin
    cause_idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        cause_idx = 3'(i);
      end
    end
  end

  // Service handshake; ack is honoured only in REQ and beats a simultaneous req drop.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (interrupt_ack) begin
          state_d = StService;
          cause_d = req ? {1'b1, 4'b0000, cause_idx} : 8'h00;
        end else if (!req) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (wr_eoi) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read mux, registered every cycle so data is ready on the second INPUT cycle.
  always_comb begin
    pend8                = '0;
    mask8                = '0;
    pend8[NUM_SRC-1:0]   = pending_q;
    mask8[NUM_SRC-1:0]   = mask_q;
    case (port_id)
      AddrPend:  in_port_d = pend8;
      AddrMask:  in_port_d = mask8;
      AddrCause: in_port_d = cause_q;
      default:   in_port_d = 8'h00;
    endcase
  end

  // State registers with synchronous reset; a reset in SERVICE drops straight to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= 8'h00;
      state_q   <= StIdle;
      in_port_q <= 8'h00;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      state_q   <= state_d;
      in_port_q <= in_port_d;
    end
  end

  // Request is a pure state decode, so it is glitch-free toward the processor.
  always_comb begin
    interrupt = (state_q == StReq);
    in_port   = in_port_q;
  end

endmodule

// File: tb/tb_pb_irq_ctrl.sv
// Directed self-checking bench for pb_irq_ctrl at default parameters (BASE_PORT = 8'hF0).
module tb_pb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_src = 8'h00;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] in_port;

  int total = 0;
  int bad = 0;

  pb_irq_ctrl #(
    .NUM_SRC  (8),
    .BASE_PORT(8'hF0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_src      (irq_src),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id      = 8'h00;
    out_port     = 8'h00;
  endtask

  task automatic rd(input logic [7:0] addr);
    port_id     = addr;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic pulse_ack;
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] offs [4];
    offs = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL reset_irq: got %b want 0", interrupt);
    end
    for (int i = 0; i < 4; i++) begin
      rd(offs[i]);
      total++;
      if (in_port !== 8'h00) begin
        bad++; $display("FAIL reset_rd_%h: got %h want 00", offs[i], in_port);
      end
    end
  endtask

  task automatic test_basic;
    wr(8'hF1, 8'h05);
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL basic_early: got %b want 0", interrupt);
    end
    rd(8'hF0);
    total++;
    if (in_port !== 8'h04) begin
      bad++; $display("FAIL basic_pend: got %h want 04", in_port);
    end
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL basic_irq: got %b want 1", interrupt);
    end
    pulse_ack();
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL basic_ack_drop: got %b want 0", interrupt);
    end
    rd(8'hF2);
    total++;
    if (in_port !== 8'h82) begin
      bad++; $display("FAIL basic_cause: got %h want 82", in_port);
    end
    wr(8'hF0, 8'h04);
    wr(8'hF3, 8'h00);
    tick();
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL basic_after_eoi: got %b want 0", interrupt);
    end
  endtask

  task automatic test_priority;
    wr(8'hF1, 8'h12);
    irq_src = 8'h12;
    tick();
    irq_src = 8'h00;
    tick();
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL prio_irq: got %b want 1", interrupt);
    end
    pulse_ack();
    rd(8'hF2);
    total++;
    if (in_port !== 8'h81) begin
      bad++; $display("FAIL prio_cause1: got %h want 81", in_port);
    end
    wr(8'hF0, 8'h02);
    wr(8'hF3, 8'h00);
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL prio_gap: got %b want 0", interrupt);
    end
    tick();
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL prio_rereq: got %b want 1", interrupt);
    end
    pulse_ack();
    rd(8'hF2);
    total++;
    if (in_port !== 8'h84) begin
      bad++; $display("FAIL prio_cause4: got %h want 84", in_port);
    end
    wr(8'hF0, 8'h10);
    wr(8'hF3, 8'h00);
  endtask

  task automatic test_mask_drop;
    wr(8'hF1, 8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL mdrop_irq: got %b want 1", interrupt);
    end
    wr(8'hF1, 8'h00);
    tick();
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL mdrop_low: got %b want 0", interrupt);
    end
    rd(8'hF0);
    total++;
    if (in_port !== 8'h01) begin
      bad++; $display("FAIL mdrop_pend: got %h want 01", in_port);
    end
    pulse_ack();
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL idle_ack_irq: got %b want 0", interrupt);
    end
    rd(8'hF2);
    total++;
    if (in_port !== 8'h84) begin
      bad++; $display("FAIL idle_ack_cause: got %h want 84", in_port);
    end
    wr(8'hF0, 8'h01);
    rd(8'hF0);
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL mdrop_w1c: got %h want 00", in_port);
    end
  endtask

  task automatic test_set_beats_clear;
    irq_src = 8'h08;
    wr(8'hF0, 8'h08);
    irq_src = 8'h00;
    rd(8'hF0);
    total++;
    if (in_port !== 8'h08) begin
      bad++; $display("FAIL set_wins: got %h want 08", in_port);
    end
    wr(8'hF0, 8'h08);
    wr(8'hF5, 8'hFF);
    rd(8'hF0);
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL unmapped_pend: got %h want 00", in_port);
    end
    rd(8'hF1);
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL unmapped_mask: got %h want 00", in_port);
    end
    rd(8'hF2);
    total++;
    if (in_port !== 8'h84) begin
      bad++; $display("FAIL unmapped_cause: got %h want 84", in_port);
    end
    rd(8'hF5);
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL unmapped_rd: got %h want 00", in_port);
    end
  endtask

  task automatic test_capture_mode;
    irq_src = 8'h01;
    tick();
    tick();
    wr(8'hF0, 8'h01);
    rd(8'hF0);
`ifdef PB_IRQ_EDGE_EN
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL edge_held_w1c: got %h want 00", in_port);
    end
`else
    total++;
    if (in_port !== 8'h01) begin
      bad++; $display("FAIL level_held_w1c: got %h want 01", in_port);
    end
`endif
    irq_src = 8'h00;
    tick();
    wr(8'hF0, 8'h01);
    rd(8'hF0);
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL released_w1c: got %h want 00", in_port);
    end
  endtask

  task automatic test_reset_in_service;
    wr(8'hF1, 8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    pulse_ack();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (interrupt !== 1'b0) begin
      bad++; $display("FAIL rst_svc_irq: got %b want 0", interrupt);
    end
    rd(8'hF1);
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL rst_svc_mask: got %h want 00", in_port);
    end
    rd(8'hF2);
    total++;
    if (in_port !== 8'h00) begin
      bad++; $display("FAIL rst_svc_cause: got %h want 00", in_port);
    end
    wr(8'hF1, 8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    total++;
    if (interrupt !== 1'b1) begin
      bad++; $display("FAIL rst_svc_rereq: got %b want 1", interrupt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask_drop();
    test_set_beats_clear();
    test_capture_mode();
    test_reset_in_service();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
